instr_line_fill: RTL and testbench
==================================

Name: instr_line_fill

Overview:
- Instruction-side miss handler between the external memory bus and the cpu's instruction cache fill port.
- On an instruction-cache miss (cacheMissFetch with instrAddr), it issues one line-aligned read burst to memory.
- It assembles BEATS narrow data beats into one LINE_W line.
- It presents the line to the cpu as mcInstrIn with a one-cycle mcInstrValid strobe.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 512, cache line width in bits (64 bytes)
BEAT_W, 128, memory data beat width; BEATS = LINE_W/BEAT_W = 4; LINE_W must be an integer multiple of BEAT_W

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset; low = reset, sampled with no clock dependency
cacheMissFetch  input  1  cpu instruction cache miss; held high until mcInstrValid
instrAddr  input  ADDR_W  missing instruction byte address
memReq  output  1  read request to memory
memAddr  output  ADDR_W  line-aligned request address
memGrant  input  1  memory accepts request this cycle
memDataValid  input  1  one data beat present on memData
memData  input  BEAT_W  data beat
mcInstrIn  output  LINE_W  assembled instruction line
mcInstrValid  output  1  one-cycle strobe, line valid
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous) clears all state and outputs:
  - state = IDLE; beat counter = 0.
  - memReq, mcInstrValid, busy = 0; memAddr = 0; mcInstrIn = 0.
- Reset asserted mid-fill aborts the fill with no mcInstrValid. The partial line is discarded.
- States: IDLE, REQ, FILL, DELIVER, COOL.
- IDLE -> REQ when cacheMissFetch = 1:
  - latch memAddr = {instrAddr[ADDR_W-1:6], 6'b0}; lower address bits are ignored;
  - clear beat counter.
- REQ:
  - memReq = 1 and memAddr is stable until the cycle memGrant = 1 (inclusive); then -> FILL.
  - memReq drops the cycle after the grant.
- FILL, on each cycle with memDataValid = 1:
  - write memData into line bits [k*BEAT_W +: BEAT_W], where k = beat counter;
  - increment the counter.
  - Beat 0 fills the LSBs, so the instruction at the line base address is mcInstrIn[31:0].
- Back-to-back beats (memDataValid high every cycle) are supported. Gaps of any length are allowed.
- On capture of beat BEATS-1 -> DELIVER. The counter wraps to 0.
- DELIVER: mcInstrValid = 1 for exactly one cycle with the complete line on mcInstrIn; then -> COOL.
  - Latency from grant with gapless beats: mcInstrValid is high BEATS+1 cycles after the grant cycle.
- COOL: one cycle, cacheMissFetch is ignored, because the cpu drops the miss one cycle after the strobe. Then -> IDLE.
- mcInstrIn holds the last delivered line until the next fill completes.
  - Beats are collected in an internal buffer, so mcInstrIn never shows a partial line.
- memDataValid outside FILL is ignored. The buffer and counter are unchanged.
- memGrant outside REQ is ignored.
- cacheMissFetch changes while busy are ignored. instrAddr is sampled only on the IDLE -> REQ transition.
- A miss in the same cycle as the COOL -> IDLE transition is not accepted that cycle. It is accepted the next cycle in IDLE.
- busy = 1 in REQ, FILL, DELIVER and COOL.

Test Plan:
- Reset then basic fill:
  - Stimulus: rst low 2 cycles, release; cacheMissFetch = 1, instrAddr = 0x0000_1044; grant after 3 cycles; beats 0x..0,1,2,3 gapless, beat0 = {96'h0, 32'hC2B74000}.
  - Required: memReq high 4 cycles with memAddr = 0x0000_1040.
  - Required: mcInstrValid exactly one cycle, 5 cycles after grant; mcInstrIn[31:0] = 32'hC2B74000; beats are in order in the 128-bit slices.
- Gapped beats:
  - Stimulus: same request, with 2 idle cycles between every beat, plus spurious memDataValid pulses during REQ.
  - Required: identical line; the spurious pulses are not captured; mcInstrValid only after the 4th FILL beat.
- Miss held across delivery:
  - Stimulus: cacheMissFetch stays high through mcInstrValid and drops one cycle later.
  - Required: no second memReq; busy returns to 0 after COOL.
- Back-to-back misses:
  - Stimulus: a second miss (instrAddr = 0x0000_2000) asserted in the first IDLE cycle after COOL.
  - Required: new memReq with memAddr = 0x0000_2000; the prior line stays on mcInstrIn until the new strobe.
- Reset mid-fill:
  - Stimulus: rst low after 2 of 4 beats.
  - Required: immediately (asynchronous) all outputs 0 and busy 0; no mcInstrValid; a following fresh miss completes normally.

Source files
------------

// File: rtl/instr_line_fill.sv
// Instruction-side line fill engine: turns an I-cache miss into one
// line-aligned memory read burst, gathers BEATS data beats into a full
// line and hands it to the cpu with a single-cycle valid strobe.
module instr_line_fill #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cacheMissFetch,
  input  logic [ADDR_W-1:0] instrAddr,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memGrant,
  input  logic              memDataValid,
  input  logic [BEAT_W-1:0] memData,
  output logic [LINE_W-1:0] mcInstrIn,
  output logic              mcInstrValid,
  output logic              busy
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    FILL    = 3'd2,
    DELIVER = 3'd3,
    COOL    = 3'd4
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [LINE_W-1:0]  line_buf;
  logic [LINE_W-1:0]  line_next;
  logic               accept_miss;
  logic               capture;
  logic               last_beat;

  // Byte offset within the line never reaches the bus; requests are line aligned.
  logic unused_offset;
  assign unused_offset = &{1'b0, instrAddr[OFF_W-1:0]};

  assign accept_miss = (state == IDLE) && cacheMissFetch;
  assign capture     = (state == FILL) && memDataValid;
  assign last_beat   = capture && (beat_cnt == CNT_W'(BEATS - 1));

  assign memReq       = (state == REQ);
  assign mcInstrValid = (state == DELIVER);
  assign busy         = (state != IDLE);

  // State register; an asynchronous reset abandons any fill in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: each fill is request, beats, one-cycle delivery, one-cycle cool-down.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cacheMissFetch) next_state = REQ;
      REQ:     if (memGrant) next_state = FILL;
      FILL:    if (last_beat) next_state = DELIVER;
      DELIVER: next_state = COOL;
      COOL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Merge the incoming beat into its slot; beat 0 lands in the line LSBs.
  always_comb begin
    line_next = line_buf;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt == CNT_W'(k)) begin
        line_next[k*BEAT_W +: BEAT_W] = memData;
      end
    end
  end

  // Request address, beat counter, assembly buffer and the delivered line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memAddr   <= '0;
      beat_cnt  <= '0;
      line_buf  <= '0;
      mcInstrIn <= '0;
    end else begin
      if (accept_miss) begin
        memAddr  <= {instrAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        beat_cnt <= '0;
      end
      if (capture) begin
        line_buf <= line_next;
        if (last_beat) begin
          beat_cnt  <= '0;
          // Only a complete line ever reaches the cpu-facing register.
          mcInstrIn <= line_next;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_line_fill.sv
// Directed bench for instr_line_fill: basic, gapped, held-miss,
// back-to-back and reset-mid-fill scenarios with hand-built expected lines.
module tb_instr_line_fill;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 512;
  localparam int BEAT_W = 128;

  logic              clk;
  logic              rst;
  logic              cacheMissFetch;
  logic [ADDR_W-1:0] instrAddr;
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memGrant;
  logic              memDataValid;
  logic [BEAT_W-1:0] memData;
  logic [LINE_W-1:0] mcInstrIn;
  logic              mcInstrValid;
  logic              busy;

  int tests;
  int fails;

  logic [BEAT_W-1:0] b [4];
  logic [BEAT_W-1:0] c [4];
  logic [LINE_W-1:0] line1;
  logic [LINE_W-1:0] line2;
  logic [BEAT_W-1:0] junk;

  instr_line_fill #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W),
    .BEAT_W(BEAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cacheMissFetch(cacheMissFetch),
    .instrAddr(instrAddr),
    .memReq(memReq),
    .memAddr(memAddr),
    .memGrant(memGrant),
    .memDataValid(memDataValid),
    .memData(memData),
    .mcInstrIn(mcInstrIn),
    .mcInstrValid(mcInstrValid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    b[0] = 128'h00000000_00000000_00000000_C2B74000;
    b[1] = 128'h11111111_11111111_11111111_00000001;
    b[2] = 128'h22222222_22222222_22222222_00000002;
    b[3] = 128'h33333333_33333333_33333333_00000003;
    c[0] = 128'hA0A0A0A0_A0A0A0A0_A0A0A0A0_13000013;
    c[1] = 128'hB1B1B1B1_B1B1B1B1_B1B1B1B1_13000113;
    c[2] = 128'hC2C2C2C2_C2C2C2C2_C2C2C2C2_13000213;
    c[3] = 128'hD3D3D3D3_D3D3D3D3_D3D3D3D3_13000313;
    line1 = {b[3], b[2], b[1], b[0]};
    line2 = {c[3], c[2], c[1], c[0]};
    junk  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    rst = 1'b0;
    cacheMissFetch = 1'b0;
    instrAddr = '0;
    memGrant = 1'b0;
    memDataValid = 1'b0;
    memData = '0;

    // Reset for two cycles
    tick();
    tick();
    chk_bit("rst_memReq", memReq, 1'b0);
    chk_addr("rst_memAddr", memAddr, 32'h0);
    chk_bit("rst_valid", mcInstrValid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_line("rst_line", mcInstrIn, '0);

    // Basic gapless fill, miss held through delivery and cool-down
    rst = 1'b1;
    cacheMissFetch = 1'b1;
    instrAddr = 32'h0000_1044;
    tick();
    instrAddr = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      chk_bit("req_high", memReq, 1'b1);
      chk_addr("req_addr", memAddr, 32'h0000_1040);
      chk_bit("req_busy", busy, 1'b1);
      if (i == 3) memGrant = 1'b1;
      tick();
    end
    memGrant = 1'b0;
    chk_bit("req_drop", memReq, 1'b0);
    for (int k = 0; k < 4; k++) begin
      memDataValid = 1'b1;
      memData = b[k];
      chk_bit("no_early_vld", mcInstrValid, 1'b0);
      tick();
    end
    memDataValid = 1'b0;
    memData = junk;
    chk_bit("vld_strobe", mcInstrValid, 1'b1);
    chk_line("line1", mcInstrIn, line1);
    chk_addr("insn0", mcInstrIn[31:0], 32'hC2B74000);
    chk_line("slice1", {384'h0, mcInstrIn[255:128]}, {384'h0, b[1]});
    tick();
    chk_bit("vld_one_cycle", mcInstrValid, 1'b0);
    chk_bit("cool_busy", busy, 1'b1);
    chk_bit("cool_no_req", memReq, 1'b0);
    chk_line("cool_hold", mcInstrIn, line1);
    tick();
    cacheMissFetch = 1'b0;
    chk_bit("idle_busy", busy, 1'b0);
    chk_bit("held_no_req", memReq, 1'b0);
    tick();
    chk_bit("held_no_req2", memReq, 1'b0);
    chk_bit("idle_busy2", busy, 1'b0);

    // Gapped beats with spurious data-valid pulses during REQ
    cacheMissFetch = 1'b1;
    instrAddr = 32'h0000_1044;
    tick();
    memDataValid = 1'b1;
    memData = junk;
    chk_bit("g_req", memReq, 1'b1);
    tick();
    memGrant = 1'b1;
    tick();
    memGrant = 1'b0;
    memDataValid = 1'b0;
    chk_bit("g_req_drop", memReq, 1'b0);
    for (int k = 0; k < 4; k++) begin
      memDataValid = 1'b1;
      memData = b[k];
      tick();
      memDataValid = 1'b0;
      memData = junk;
      if (k < 3) begin
        for (int g = 0; g < 2; g++) begin
          chk_bit("gap_no_vld", mcInstrValid, 1'b0);
          tick();
        end
      end
    end
    chk_bit("g_vld", mcInstrValid, 1'b1);
    chk_line("g_line", mcInstrIn, line1);
    tick();
    cacheMissFetch = 1'b0;
    chk_bit("g_vld_one", mcInstrValid, 1'b0);

    // Back-to-back miss in the first IDLE cycle after COOL
    tick();
    chk_bit("b2b_idle", busy, 1'b0);
    cacheMissFetch = 1'b1;
    instrAddr = 32'h0000_2000;
    tick();
    chk_bit("b2b_req", memReq, 1'b1);
    chk_addr("b2b_addr", memAddr, 32'h0000_2000);
    chk_line("b2b_hold_req", mcInstrIn, line1);
    memGrant = 1'b1;
    tick();
    memGrant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      memDataValid = 1'b1;
      memData = c[k];
      chk_line("b2b_hold_fill", mcInstrIn, line1);
      tick();
    end
    memDataValid = 1'b0;
    chk_bit("b2b_vld", mcInstrValid, 1'b1);
    chk_line("line2", mcInstrIn, line2);
    tick();
    cacheMissFetch = 1'b0;
    tick();

    // Reset asserted after two of four beats
    cacheMissFetch = 1'b1;
    instrAddr = 32'h0000_3085;
    tick();
    chk_addr("rm_addr", memAddr, 32'h0000_3080);
    memGrant = 1'b1;
    tick();
    memGrant = 1'b0;
    memDataValid = 1'b1;
    memData = b[0];
    tick();
    memData = b[1];
    tick();
    memDataValid = 1'b0;
    rst = 1'b0;
    cacheMissFetch = 1'b0;
    #1;
    chk_bit("rm_memReq", memReq, 1'b0);
    chk_bit("rm_busy", busy, 1'b0);
    chk_bit("rm_valid", mcInstrValid, 1'b0);
    chk_addr("rm_memAddr", memAddr, 32'h0);
    chk_line("rm_line", mcInstrIn, '0);
    tick();
    rst = 1'b1;
    tick();
    chk_bit("rm_no_vld", mcInstrValid, 1'b0);
    chk_bit("rm_idle", busy, 1'b0);
    tick();
    chk_bit("rm_no_vld2", mcInstrValid, 1'b0);

    // Fresh miss after reset completes normally
    cacheMissFetch = 1'b1;
    instrAddr = 32'h0000_1044;
    tick();
    chk_addr("fr_addr", memAddr, 32'h0000_1040);
    memGrant = 1'b1;
    tick();
    memGrant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      memDataValid = 1'b1;
      memData = b[k];
      tick();
    end
    memDataValid = 1'b0;
    chk_bit("fr_vld", mcInstrValid, 1'b1);
    chk_line("fr_line", mcInstrIn, line1);
    tick();
    cacheMissFetch = 1'b0;
    tick();
    chk_bit("fr_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
